// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if
//   Bundles the reservation-station request lines and the functional-unit
//   grant lines of the issue scheduler.
//   Modports:
//     master : reservation-station / FU side (drives requests, sees grants)
//     slave  : scheduler side (sees requests, drives grants)
//   Signals:
//     req_valid  [N_ENTRIES] entry occupied with both sources ready
//     req_mem    [N_ENTRIES] entry class, 1 = MEM, 0 = ALU
//     head_ptr   [IDX_W]     index of the oldest occupied entry
//     fu_ready   [3]         bit0 ALU0, bit1 ALU1, bit2 MEM
//     grant_vld  [3]         per-FU grant valid
//     grant_idx0/1/2 [IDX_W] granted entry for ALU0 / ALU1 / MEM
//     clear_mask [N_ENTRIES] release mask back to the RS
//     mem_busy               MEM unit inside its busy window
//     issue_cnt  [16]        total grants since reset, wrapping
interface issue_scheduler_if #(
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = 4
);
    logic [N_ENTRIES-1:0] req_valid;
    logic [N_ENTRIES-1:0] req_mem;
    logic [IDX_W-1:0]     head_ptr;
    logic [2:0]           fu_ready;
    logic [2:0]           grant_vld;
    logic [IDX_W-1:0]     grant_idx0;
    logic [IDX_W-1:0]     grant_idx1;
    logic [IDX_W-1:0]     grant_idx2;
    logic [N_ENTRIES-1:0] clear_mask;
    logic                 mem_busy;
    logic [15:0]          issue_cnt;

    modport master (
        output req_valid, req_mem, head_ptr, fu_ready,
        input  grant_vld, grant_idx0, grant_idx1, grant_idx2,
               clear_mask, mem_busy, issue_cnt
    );

    modport slave (
        input  req_valid, req_mem, head_ptr, fu_ready,
        output grant_vld, grant_idx0, grant_idx1, grant_idx2,
               clear_mask, mem_busy, issue_cnt
    );
endinterface

// File: rtl/issue_scheduler.sv
// issue_scheduler
//   Age-ordered issue arbiter between the reservation station and the three
//   functional units (ALU0, ALU1, MEM). Scans eligible entries from head_ptr
//   (wrapping), grants up to one entry per FU, registers the grants.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : issue_scheduler_if.slave (requests in, grants/status out)
//   Parameters: N_ENTRIES (power of two, 4..64), IDX_W = log2(N_ENTRIES),
//               MEM_LAT (1..15) MEM busy window length.
//   Optional feature: define ISSUE_MEM_BUSY_EN to build the MEM busy
//   down-counter; otherwise mem_busy is tied low and MEM availability is
//   fu_ready[2] alone.
module issue_scheduler #(
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = 4,
    parameter int MEM_LAT   = 3
) (
    input  logic clk,
    input  logic rst,
    issue_scheduler_if.slave bus
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("issue_scheduler: MEM_LAT must be 1..15");
    end
    if (N_ENTRIES != (1 << IDX_W)) begin : g_bad_idx_w
        $error("issue_scheduler: N_ENTRIES must equal 2**IDX_W");
    end

    logic [2:0]           r_grant_vld;
    logic [IDX_W-1:0]     r_grant_idx0;
    logic [IDX_W-1:0]     r_grant_idx1;
    logic [IDX_W-1:0]     r_grant_idx2;
    logic [N_ENTRIES-1:0] r_clear_mask;
    logic [15:0]          r_issue_cnt;

    logic [N_ENTRIES-1:0] w_elig;
    logic [IDX_W-1:0]     w_scan;
    logic                 w_mem_found;
    logic [IDX_W-1:0]     w_mem_idx;
    logic [1:0]           w_alu_cnt;
    logic [IDX_W-1:0]     w_alu_first;
    logic [IDX_W-1:0]     w_alu_second;
    logic                 w_mem_busy;
    logic                 w_mem_avail;
    logic [2:0]           w_grant_vld;
    logic [IDX_W-1:0]     w_grant_idx0;
    logic [IDX_W-1:0]     w_grant_idx1;
    logic [IDX_W-1:0]     w_grant_idx2;
    logic [N_ENTRIES-1:0] w_clear_mask;
    logic [15:0]          w_pop;

    // Last edge's grants double as the in-flight mask: the RS has not yet
    // dropped those entries, so they must not be granted again this edge.
    always_comb begin
        w_elig       = bus.req_valid & ~r_clear_mask;
        w_scan       = '0;
        w_mem_found  = 1'b0;
        w_mem_idx    = '0;
        w_alu_cnt    = 2'd0;
        w_alu_first  = '0;
        w_alu_second = '0;
        // Index arithmetic wraps naturally at IDX_W bits, giving the
        // head_ptr, head_ptr+1, ... modulo-N age order.
        for (int unsigned k = 0; k < N_ENTRIES; k++) begin
            w_scan = bus.head_ptr + IDX_W'(k);
            if (w_elig[w_scan]) begin
                if (bus.req_mem[w_scan]) begin
                    if (!w_mem_found) begin
                        w_mem_found = 1'b1;
                        w_mem_idx   = w_scan;
                    end
                end else if (w_alu_cnt == 2'd0) begin
                    w_alu_first = w_scan;
                    w_alu_cnt   = 2'd1;
                end else if (w_alu_cnt == 2'd1) begin
                    w_alu_second = w_scan;
                    w_alu_cnt    = 2'd2;
                end
            end
        end
    end

    always_comb begin
        w_mem_avail  = bus.fu_ready[2] & ~w_mem_busy;
        w_grant_vld  = '0;
        w_grant_idx0 = '0;
        w_grant_idx1 = '0;
        w_grant_idx2 = '0;
        if (w_mem_found && w_mem_avail) begin
            w_grant_vld[2] = 1'b1;
            w_grant_idx2   = w_mem_idx;
        end
        if (w_alu_cnt != 2'd0) begin
            if (bus.fu_ready[0]) begin
                w_grant_vld[0] = 1'b1;
                w_grant_idx0   = w_alu_first;
                // Second-oldest ALU op only rides along when the oldest
                // went to ALU0.
                if (bus.fu_ready[1] && (w_alu_cnt == 2'd2)) begin
                    w_grant_vld[1] = 1'b1;
                    w_grant_idx1   = w_alu_second;
                end
            end else if (bus.fu_ready[1]) begin
                w_grant_vld[1] = 1'b1;
                w_grant_idx1   = w_alu_first;
            end
        end
    end

    always_comb begin
        w_clear_mask = '0;
        if (w_grant_vld[0]) w_clear_mask[w_grant_idx0] = 1'b1;
        if (w_grant_vld[1]) w_clear_mask[w_grant_idx1] = 1'b1;
        if (w_grant_vld[2]) w_clear_mask[w_grant_idx2] = 1'b1;
    end

    // Counts the grants currently presented on grant_vld.
    assign w_pop = 16'(r_grant_vld[0]) + 16'(r_grant_vld[1]) + 16'(r_grant_vld[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_vld  <= '0;
            r_grant_idx0 <= '0;
            r_grant_idx1 <= '0;
            r_grant_idx2 <= '0;
            r_clear_mask <= '0;
            r_issue_cnt  <= '0;
        end else begin
            r_grant_vld  <= w_grant_vld;
            r_grant_idx0 <= w_grant_idx0;
            r_grant_idx1 <= w_grant_idx1;
            r_grant_idx2 <= w_grant_idx2;
            r_clear_mask <= w_clear_mask;
            r_issue_cnt  <= r_issue_cnt + w_pop;
        end
    end

`ifdef ISSUE_MEM_BUSY_EN
    logic [3:0] r_mem_cnt;

    // A new MEM grant reloads the counter even while it is still draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_cnt <= '0;
        end else if (w_grant_vld[2]) begin
            r_mem_cnt <= 4'(MEM_LAT - 1);
        end else if (r_mem_cnt != 4'd0) begin
            r_mem_cnt <= r_mem_cnt - 4'd1;
        end
    end

    assign w_mem_busy = (r_mem_cnt != 4'd0);
`else
    assign w_mem_busy = 1'b0;
`endif

    assign bus.grant_vld  = r_grant_vld;
    assign bus.grant_idx0 = r_grant_idx0;
    assign bus.grant_idx1 = r_grant_idx1;
    assign bus.grant_idx2 = r_grant_idx2;
    assign bus.clear_mask = r_clear_mask;
    assign bus.mem_busy   = w_mem_busy;
    assign bus.issue_cnt  = r_issue_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler
//   Self-checking bench for issue_scheduler (N_ENTRIES=16, MEM_LAT=3).
//   Directed vector table, hand-written MEM-busy and mid-stream reset
//   sequences, and random stimulus, all checked against a behavioural model.
module tb_issue_scheduler;
    localparam int N   = 16;
    localparam int IW  = 4;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_scheduler_if #(.N_ENTRIES(N), .IDX_W(IW)) bus();

    issue_scheduler #(.N_ENTRIES(N), .IDX_W(IW), .MEM_LAT(LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [2:0]    m_vld   = '0;
    logic [IW-1:0] m_idx0  = '0;
    logic [IW-1:0] m_idx1  = '0;
    logic [IW-1:0] m_idx2  = '0;
    logic [N-1:0]  m_clear = '0;
    logic [15:0]   m_cnt   = '0;
    logic          m_busy  = 1'b0;
    logic          m_rst   = 1'b1;
    int            edge_n  = 0;
    int            m_last_mem = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge(input logic r, input logic [N-1:0] v, input logic [N-1:0] m,
                              input logic [IW-1:0] h, input logic [2:0] fr);
        int elig_mem[$];
        int elig_alu[$];
        logic busy_before;
        int i;
        edge_n++;
        if (r) begin
            m_vld = '0; m_idx0 = '0; m_idx1 = '0; m_idx2 = '0;
            m_clear = '0; m_cnt = '0; m_busy = 1'b0; m_rst = 1'b1;
            m_last_mem = -100;
            return;
        end
        m_rst = 1'b0;
        m_cnt = m_cnt + 16'(m_vld[0]) + 16'(m_vld[1]) + 16'(m_vld[2]);
        for (int k = 0; k < N; k++) begin
            i = (int'(h) + k) % N;
            if (v[i] && !m_clear[i]) begin
                if (m[i]) elig_mem.push_back(i);
                else      elig_alu.push_back(i);
            end
        end
`ifdef ISSUE_MEM_BUSY_EN
        busy_before = (edge_n - m_last_mem) < LAT;
`else
        busy_before = 1'b0;
`endif
        m_vld = '0; m_idx0 = '0; m_idx1 = '0; m_idx2 = '0; m_clear = '0;
        if (elig_mem.size() > 0 && fr[2] && !busy_before) begin
            m_vld[2] = 1'b1;
            m_idx2 = IW'(elig_mem[0]);
            m_clear[elig_mem[0]] = 1'b1;
            m_last_mem = edge_n;
        end
        if (elig_alu.size() > 0) begin
            if (fr[0]) begin
                m_vld[0] = 1'b1;
                m_idx0 = IW'(elig_alu[0]);
                m_clear[elig_alu[0]] = 1'b1;
                if (fr[1] && elig_alu.size() > 1) begin
                    m_vld[1] = 1'b1;
                    m_idx1 = IW'(elig_alu[1]);
                    m_clear[elig_alu[1]] = 1'b1;
                end
            end else if (fr[1]) begin
                m_vld[1] = 1'b1;
                m_idx1 = IW'(elig_alu[0]);
                m_clear[elig_alu[0]] = 1'b1;
            end
        end
`ifdef ISSUE_MEM_BUSY_EN
        m_busy = (edge_n - m_last_mem) < (LAT - 1);
`else
        m_busy = 1'b0;
`endif
    endtask

    task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] m,
                        input logic [IW-1:0] h, input logic [2:0] fr);
        rst = r;
        bus.req_valid = v;
        bus.req_mem   = m;
        bus.head_ptr  = h;
        bus.fu_ready  = fr;
        model_edge(r, v, m, h, fr);
        @(posedge clk);
        #1;
        chk("grant_vld", 32'(bus.grant_vld), 32'(m_vld));
        chk("clear_mask", 32'(bus.clear_mask), 32'(m_clear));
        chk("mem_busy", 32'(bus.mem_busy), 32'(m_busy));
        chk("issue_cnt", 32'(bus.issue_cnt), 32'(m_cnt));
        if (m_vld[0] || m_rst) chk("grant_idx0", 32'(bus.grant_idx0), 32'(m_idx0));
        if (m_vld[1] || m_rst) chk("grant_idx1", 32'(bus.grant_idx1), 32'(m_idx1));
        if (m_vld[2] || m_rst) chk("grant_idx2", 32'(bus.grant_idx2), 32'(m_idx2));
    endtask

    typedef struct {
        logic          r;
        logic [N-1:0]  v;
        logic [N-1:0]  m;
        logic [IW-1:0] h;
        logic [2:0]    fr;
        logic [2:0]    ev;
        logic [IW-1:0] e0;
        logic [IW-1:0] e1;
        logic [IW-1:0] e2;
        logic [N-1:0]  ec;
    } vec_t;

    vec_t tbl[13];
    int mem_grants;
    int busy_cycles;
    logic [N-1:0] rv;
    logic [N-1:0] rm;

    initial begin
        bus.req_valid = '0;
        bus.req_mem   = '0;
        bus.head_ptr  = '0;
        bus.fu_ready  = '0;

        //            r   valid     mem       head fu      ev      e0    e1    e2    clear
        tbl[0]  = '{1'b1, 16'h0000, 16'h0000, 4'd0,  3'b000, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000};
        tbl[1]  = '{1'b0, 16'h800A, 16'h0000, 4'd14, 3'b011, 3'b011, 4'd15,4'd1, 4'd0, 16'h8002};
        tbl[2]  = '{1'b0, 16'h800A, 16'h0000, 4'd14, 3'b011, 3'b001, 4'd3, 4'd0, 4'd0, 16'h0008};
        tbl[3]  = '{1'b1, 16'h0000, 16'h0000, 4'd0,  3'b000, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000};
        tbl[4]  = '{1'b0, 16'h0074, 16'h0024, 4'd0,  3'b111, 3'b111, 4'd4, 4'd6, 4'd2, 16'h0054};
        tbl[5]  = '{1'b1, 16'h0000, 16'h0000, 4'd0,  3'b000, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000};
        tbl[6]  = '{1'b0, 16'h0208, 16'h0000, 4'd0,  3'b010, 3'b010, 4'd0, 4'd3, 4'd0, 16'h0008};
        tbl[7]  = '{1'b1, 16'h0000, 16'h0000, 4'd0,  3'b000, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000};
        tbl[8]  = '{1'b0, 16'h0020, 16'h0000, 4'd0,  3'b001, 3'b001, 4'd5, 4'd0, 4'd0, 16'h0020};
        tbl[9]  = '{1'b0, 16'h0020, 16'h0000, 4'd0,  3'b001, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000};
        tbl[10] = '{1'b0, 16'h0020, 16'h0000, 4'd0,  3'b001, 3'b001, 4'd5, 4'd0, 4'd0, 16'h0020};
        tbl[11] = '{1'b1, 16'h0000, 16'h0000, 4'd0,  3'b000, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000};
        tbl[12] = '{1'b0, 16'h0000, 16'h0000, 4'd0,  3'b111, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0000};

        #2;
        for (int t = 0; t < 13; t++) begin
            step(tbl[t].r, tbl[t].v, tbl[t].m, tbl[t].h, tbl[t].fr);
            chk("tbl_vld", 32'(bus.grant_vld), 32'(tbl[t].ev));
            chk("tbl_clear", 32'(bus.clear_mask), 32'(tbl[t].ec));
            if (tbl[t].ev[0] || tbl[t].r) chk("tbl_idx0", 32'(bus.grant_idx0), 32'(tbl[t].e0));
            if (tbl[t].ev[1] || tbl[t].r) chk("tbl_idx1", 32'(bus.grant_idx1), 32'(tbl[t].e1));
            if (tbl[t].ev[2] || tbl[t].r) chk("tbl_idx2", 32'(bus.grant_idx2), 32'(tbl[t].e2));
        end

        // MEM entries continuously eligible, only MEM ready.
        step(1'b1, '0, '0, 4'd0, 3'b000);
        mem_grants  = 0;
        busy_cycles = 0;
        for (int t = 0; t < 9; t++) begin
            step(1'b0, 16'h000F, 16'h000F, 4'd0, 3'b100);
            if (bus.grant_vld[2]) mem_grants++;
            if (bus.mem_busy) busy_cycles++;
        end
`ifdef ISSUE_MEM_BUSY_EN
        chk("mem_grant_count", 32'(mem_grants), 32'd3);
        chk("mem_busy_cycles", 32'(busy_cycles), 32'd6);
`else
        chk("mem_grant_count", 32'(mem_grants), 32'd9);
        chk("mem_busy_cycles", 32'(busy_cycles), 32'd0);
`endif

        // Reset in the middle of active grants.
        step(1'b0, 16'hFFFF, 16'h00F0, 4'd3, 3'b111);
        step(1'b0, 16'hFFFF, 16'h00F0, 4'd3, 3'b111);
        step(1'b1, 16'hFFFF, 16'h00F0, 4'd3, 3'b111);
        chk("rst_vld", 32'(bus.grant_vld), 32'd0);
        chk("rst_clear", 32'(bus.clear_mask), 32'd0);
        chk("rst_cnt", 32'(bus.issue_cnt), 32'd0);
        chk("rst_busy", 32'(bus.mem_busy), 32'd0);
        step(1'b0, 16'hFFFF, 16'h00F0, 4'd3, 3'b111);
        chk("post_rst_vld", 32'(bus.grant_vld), 32'd7);
        chk("post_rst_cnt", 32'(bus.issue_cnt), 32'd0);

        // Random traffic against the model.
        for (int t = 0; t < 600; t++) begin
            rv = N'($urandom);
            rm = N'($urandom);
            if ($urandom_range(0, 3) == 0) rv = rv & N'($urandom);
            step(($urandom_range(0, 59) == 0), rv, rm, IW'($urandom), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
